// File: rtl/updown_cnt_pkg.sv
// updown_cnt_pkg: shared direction type and default width for the up/down counter
package updown_cnt_pkg;
    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
    localparam int DEF_WIDTH = 4;
endpackage

// File: rtl/updown_cnt_next.sv
// updown_cnt_next: next-count and boundary-event logic; UPDOWN_CNT_SATURATE_EN selects hold instead of wrap
module updown_cnt_next
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_val,
    input  logic             en,
    input  logic             updown,
    output logic [WIDTH-1:0] nxt,
    output logic             evt_up,
    output logic             evt_dn
);
    cnt_dir_e dir;
    logic [WIDTH-1:0] up_hit, dn_hit;
    assign dir    = cnt_dir_e'(updown);
    assign evt_up = en && dir == CNT_UP && count >= max_val;
    assign evt_dn = en && dir == CNT_DOWN && count == '0;
`ifdef UPDOWN_CNT_SATURATE_EN
    assign up_hit = max_val;
    assign dn_hit = '0;
`else
    assign up_hit = '0;
    assign dn_hit = max_val;
`endif
    always_comb begin
        nxt = count;
        if (en)
            nxt = dir == CNT_UP ? (evt_up ? up_hit : WIDTH'(count + 1'b1))
                : evt_dn ? dn_hit
                : count > max_val ? max_val : WIDTH'(count - 1'b1);
    end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with load, modulo, wrap pulse and sticky flags (UPDOWN_CNT_SATURATE_EN: saturate)
module updown_counter_param
    import updown_cnt_pkg::*;
#(
    parameter int             WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_flag,
    output logic             unf_flag
);
    logic [WIDTH-1:0] nxt, ld;
    logic evt_up, evt_dn, hit_up, hit_dn;
    updown_cnt_next #(.WIDTH(WIDTH)) u_next (
        .count   (count),
        .max_val (max_val),
        .en      (en),
        .updown  (updown),
        .nxt     (nxt),
        .evt_up  (evt_up),
        .evt_dn  (evt_dn)
    );
    assign ld     = load_val > max_val ? max_val : load_val;
    assign hit_up = !load && evt_up;
    assign hit_dn = !load && evt_dn;
    assign tc     = updown ? count >= max_val : count == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= RST_VAL;
            wrap     <= 1'b0;
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            count    <= load ? ld : nxt;
            wrap     <= hit_up || hit_dn;
            ovf_flag <= hit_up || (ovf_flag && !clr_flags);
            unf_flag <= hit_dn || (unf_flag && !clr_flags);
        end
    end
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed and random checks against a behavioural model of the counter
module tb_updown_counter_param;
    logic clk = 1'b0, reset = 1'b1, en = 1'b0, updown = 1'b1, load = 1'b0, clr_flags = 1'b0;
    logic [3:0] load_val = '0, max_val = 4'd15, count;
    logic tc, wrap, ovf_flag, unf_flag;
    int checks = 0, errors = 0;
    int m_count = 0, m_wrap = 0, m_ovf = 0, m_unf = 0;
    bit started = 0;
`ifdef UPDOWN_CNT_SATURATE_EN
    localparam bit SAT = 1;
`else
    localparam bit SAT = 0;
`endif

    updown_counter_param #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_flags(clr_flags),
        .count(count), .tc(tc), .wrap(wrap), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: ranges and events computed with plain integer arithmetic
    always @(posedge clk) begin
        int mx, c, up_ev, dn_ev;
        mx = max_val;
        c  = m_count;
        if (reset) begin
            m_count = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
        end else if (load) begin
            m_count = (load_val > mx) ? mx : load_val;
            m_wrap = 0;
            if (clr_flags) begin m_ovf = 0; m_unf = 0; end
        end else begin
            up_ev = (en && updown && c >= mx) ? 1 : 0;
            dn_ev = (en && !updown && c == 0) ? 1 : 0;
            if (en && updown)
                m_count = up_ev ? (SAT ? mx : 0) : c + 1;
            else if (en)
                m_count = dn_ev ? (SAT ? 0 : mx) : (c > mx ? mx : c - 1);
            m_wrap = up_ev | dn_ev;
            m_ovf  = up_ev | (clr_flags ? 0 : m_ovf);
            m_unf  = dn_ev | (clr_flags ? 0 : m_unf);
        end
        started = 1;
    end

    always @(negedge clk) if (started) begin
        chk("count", count, m_count);
        chk("tc", tc, updown ? (m_count >= max_val) : (m_count == 0));
        chk("wrap", wrap, m_wrap);
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("unf_flag", unf_flag, m_unf);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        // 1: reset, then full up sweep with wrap
        tick(2);
        chk("rst_count", count, 0);
        chk("rst_flags", {wrap, ovf_flag, unf_flag}, 0);
        reset = 0; en = 1; updown = 1; max_val = 15;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("t1_count", count, i % 16);
            if (i == 15) chk("t1_tc15", tc, 1);
        end
        chk("t1_wrap", wrap, 1);
        chk("t1_ovf", ovf_flag, 1);
        chk("t1_unf", unf_flag, 0);
        // 2: down sweep with max_val=9
        max_val = 9; updown = 0;
        tick();
        chk("t2_first", count, 9);
        chk("t2_unf", unf_flag, 1);
        chk("t2_wrap", wrap, 1);
        tick(9);
        chk("t2_zero", count, 0);
        chk("t2_tc", tc, 1);
        tick();
        chk("t2_rewrap", count, 9);
        // 3: clamped load, then load with en overriding count
        en = 0; load = 1; load_val = 12;
        tick();
        chk("t3_clamp", count, 9);
        load_val = 3; en = 1; updown = 1;
        tick();
        chk("t3_load", count, 3);
        chk("t3_nowrap", wrap, 0);
        // 4: set beats clear on the same edge
        load_val = 9;
        tick();
        load = 0; clr_flags = 1;
        tick();
        chk("t4_wrapcnt", count, SAT ? 9 : 0);
        chk("t4_ovf_set", ovf_flag, 1);
        chk("t4_unf_clr", unf_flag, 0);
        en = 0;
        tick();
        chk("t4_ovf_clr", ovf_flag, 0);
        clr_flags = 0;
        // 5: reset wins over load and en
        en = 1; load = 1; load_val = 9;
        tick();
        load = 0;
        tick();
        load = 1; load_val = 7; en = 0;
        tick();
        chk("t5_at7", count, 7);
        reset = 1; load = 1; en = 1; load_val = 2;
        tick();
        chk("t5_count", count, 0);
        chk("t5_outs", {wrap, ovf_flag, unf_flag}, 0);
        reset = 0; load = 0;
        // 6: saturation vs wrap from 14 with max 15
        max_val = 15; load = 1; load_val = 14;
        tick();
        load = 0; updown = 1; en = 1;
        tick();
        chk("t6_a", count, 15);
        tick();
        chk("t6_b", count, SAT ? 15 : 0);
        chk("t6_wrap", wrap, 1);
        tick();
        chk("t6_c", count, SAT ? 15 : 1);
        chk("t6_ovf", ovf_flag, 1);
        // max_val=0: every enabled cycle is an event
        max_val = 0; load = 1; load_val = 5;
        tick();
        chk("mx0_load", count, 0);
        load = 0; updown = 0;
        tick();
        chk("mx0_cnt", count, 0);
        chk("mx0_wrap", wrap, 1);
        chk("mx0_unf", unf_flag, 1);
        // stale count above a lowered max_val
        max_val = 12; load = 1; load_val = 11;
        tick();
        load = 0; en = 0; max_val = 4;
        tick();
        en = 1; updown = 0;
        tick();
        chk("stale_dn", count, 4);
        chk("stale_nowrap", wrap, 0);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) max_val = 4'($urandom_range(15));
            if ($urandom_range(299) == 0) max_val = 0;
            reset     = ($urandom_range(59) == 0);
            load      = ($urandom_range(7) == 0);
            load_val  = 4'($urandom_range(15));
            en        = ($urandom_range(3) != 0);
            updown    = ($urandom_range(2) != 0);
            clr_flags = ($urandom_range(9) == 0);
            tick();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
